// File: rtl/counter_down_load.sv
// counter_down_load
// Loadable down-counter with a two-state IDLE/COUNT controller.
// A start in IDLE loads i-1 (saturated to the M-bit range) and the counter
// then walks down to zero on enabled edges, pulsing done at terminal count.
// An i of zero produces an immediate done pulse without ever going busy.
//
// Optional feature: define COUNTER_DOWN_RELOAD_EN for periodic mode, where
// terminal count reloads the latched start value and the counter keeps
// running until stop or reset. Without the macro the counter is one-shot.
module counter_down_load #(
    parameter int M  = 3,
    parameter int ni = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          en,
    input  logic          stop,
    input  logic [ni-1:0] i,
    output logic [M-1:0]  out,
    output logic          busy,
    output logic          done
);

    // Working width for the load arithmetic: wide enough for both i and out.
    localparam int W = (ni > M) ? ni : M;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t         state_q;
    logic [M-1:0]   out_q;
    logic           busy_q;
    logic           done_q;

    logic [M-1:0]   startVal_d;

    // Converts a load value into the first count value: v-1, clamped to the
    // largest M-bit value when i is wider than the output. Callers only pass
    // non-zero values, so the decrement never wraps.
    function automatic logic [M-1:0] satLoad(input logic [ni-1:0] v);
        logic [W-1:0] wide;
        logic [W-1:0] maxVal;
        wide   = W'(v) - W'(1);
        maxVal = W'({M{1'b1}});
        if (wide > maxVal) begin
            satLoad = {M{1'b1}};
        end else begin
            satLoad = wide[M-1:0];
        end
    endfunction

    assign startVal_d = satLoad(i);

`ifdef COUNTER_DOWN_RELOAD_EN
    // In periodic mode the start value has to survive the whole run so each
    // period can restart from it; i itself may change freely while counting.
    logic [ni-1:0]  load_q;
    logic [M-1:0]   reloadVal_d;

    assign reloadVal_d = satLoad(load_q);
`endif

    // Controller and all registered outputs live in one clocked process so
    // out, busy and done always change together on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef COUNTER_DOWN_RELOAD_EN
            load_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (i != '0) begin
                            out_q   <= startVal_d;
                            busy_q  <= 1'b1;
                            state_q <= COUNT;
`ifdef COUNTER_DOWN_RELOAD_EN
                            load_q  <= i;
`endif
                        end else begin
                            done_q  <= 1'b1;
                            out_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                COUNT: begin
                    if (stop) begin
                        out_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (en) begin
                        if (out_q != '0) begin
                            out_q <= out_q - M'(1);
                        end else begin
                            done_q <= 1'b1;
`ifdef COUNTER_DOWN_RELOAD_EN
                            out_q   <= reloadVal_d;
`else
                            out_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
`endif
                        end
                    end
                end

                default: begin
                    out_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_down_load.sv
// tb_counter_down_load
// Directed test of counter_down_load with M=3, ni=3. Each task drives one
// scenario and compares {out, busy, done} against hand-computed values.
// Terminal-count scenarios follow the build: one-shot by default, periodic
// when COUNTER_DOWN_RELOAD_EN is defined.
module tb_counter_down_load;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       en;
    logic       stop;
    logic [2:0] i;
    logic [2:0] out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_down_load #(
        .M  (3),
        .ni (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .en    (en),
        .stop  (stop),
        .i     (i),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    // Advance one rising edge and settle a little past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; en = 1'b0; stop = 1'b0; i = 3'd0;
        #2;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b1 & 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_initial got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
        #10;
        reset = 1'b1;
        step();
        i = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_preload got out=%0d busy=%b done=%b want 2/1/0", out, busy, done);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_async got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
        #7;
        reset = 1'b1;
        step();
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_release got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
    endtask

    task automatic test_reset_midcount();
        i = 3'd5; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({out, busy, done} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_count got out=%0d busy=%b done=%b want 3/1/0", out, busy, done);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_abort got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_nodone got done=%b want 0", done);
        end
        i = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_restart got out=%0d busy=%b done=%b want 1/1/0", out, busy, done);
        end
        stop = 1'b1;
        step();
        stop = 1'b0; en = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_stop got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
    endtask

    task automatic test_zero_load();
        i = 3'd0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL zero_pulse got out=%0d busy=%b done=%b want 0/0/1", out, busy, done);
        end
        step();
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zero_after got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        i = 3'd0; start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({out, busy, done} !== {3'd0, 1'b0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL b2b_zero_%0d got out=%0d busy=%b done=%b want 0/0/1", k, out, busy, done);
            end
        end
        start = 1'b0;
        step();
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_end got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
    endtask

    task automatic test_stop();
        i = 3'd6; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_load got out=%0d busy=%b done=%b want 5/1/0", out, busy, done);
        end
        step();
        i = 3'd7; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_start_ignored got out=%0d busy=%b done=%b want 3/1/0", out, busy, done);
        end
        step();
        checks++;
        if (out !== 3'd2) begin
            errors++;
            $display("[TB] FAIL stop_at2 got out=%0d want 2", out);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_abort got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
        step();
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_nodone got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
        i = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_tc_load got out=%0d busy=%b done=%b want 0/1/0", out, busy, done);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_beats_tc got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
        en = 1'b0;
        i = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({out, busy, done} !== {3'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_hold_en0 got out=%0d busy=%b done=%b want 2/1/0", out, busy, done);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_en0 got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
    endtask

`ifndef COUNTER_DOWN_RELOAD_EN
    task automatic test_count_basic();
        logic [2:0] expSeq [4];
        expSeq = '{3'd3, 3'd2, 3'd1, 3'd0};
        i = 3'd5; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_load got out=%0d busy=%b done=%b want 4/1/0", out, busy, done);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({out, busy, done} !== {expSeq[k], 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL basic_step%0d got out=%0d busy=%b done=%b want %0d/1/0", k, out, busy, done, expSeq[k]);
            end
        end
        step();
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL basic_done got out=%0d busy=%b done=%b want 0/0/1", out, busy, done);
        end
        step();
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_idle got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
        en = 1'b0;
    endtask

    task automatic test_en_toggle();
        logic       enSeq  [6];
        logic [2:0] expSeq [6];
        enSeq  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        expSeq = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
        i = 3'd4; start = 1'b1; en = 1'b0;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL entog_load got out=%0d busy=%b done=%b want 3/1/0", out, busy, done);
        end
        for (int k = 0; k < 6; k++) begin
            en = enSeq[k];
            step();
            checks++;
            if ({out, busy, done} !== {expSeq[k], 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL entog_step%0d got out=%0d busy=%b done=%b want %0d/1/0", k, out, busy, done, expSeq[k]);
            end
        end
        en = 1'b1;
        step();
        en = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL entog_done got out=%0d busy=%b done=%b want 0/0/1", out, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL entog_single got done=%b want 0", done);
        end
    endtask
`else
    task automatic test_reload();
        logic [2:0] expOut  [6];
        logic       expDone [6];
        expOut  = '{3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2};
        expDone = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        i = 3'd3; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reload_load got out=%0d busy=%b done=%b want 2/1/0", out, busy, done);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if ({out, busy, done} !== {expOut[k], 1'b1, expDone[k]}) begin
                errors++;
                $display("[TB] FAIL reload_step%0d got out=%0d busy=%b done=%b want %0d/1/%b", k, out, busy, done, expOut[k], expDone[k]);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0; en = 1'b0;
        checks++;
        if ({out, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reload_stop got out=%0d busy=%b done=%b want 0/0/0", out, busy, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midcount();
        test_zero_load();
        test_back_to_back();
        test_stop();
`ifndef COUNTER_DOWN_RELOAD_EN
        test_count_basic();
        test_en_toggle();
`else
        test_reload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
